lif_neuron_array: RTL and testbench

- Time-multiplexed array of NUM_NEURONS first-order leaky integrate-and-fire neurons.
- Successor to the single-neuron LIF block. Adds:
  - parametrised width and neuron count
  - runtime threshold
  - selectable subtract/zero reset mechanism
  - refractory period
  - step handshake
- One shared update datapath visits neurons 0..N-1 sequentially, one per cycle, per timestep.

---
 rtl/lif_pkg.sv | 34 +++
 rtl/lif_neuron_array_update.sv | 56 +++++
 rtl/lif_neuron_array.sv | 183 ++++++++++++++++++
 tb/tb_lif_neuron_array.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// -----------------------------------------------------------------------------
// lif_pkg
// Shared types and constants for the leaky integrate-and-fire neuron array.
//   - state_e       : sequencer states (IDLE / RUN / DONE)
//   - RESET_*       : encodings of the reset_mode input
//   - SEG_LUT       : 7-segment patterns for digits 0..9, bit 0 = a .. bit 6 = g
//   - seg_decode()  : digit to segment pattern; codes above 9 give a blank digit
// -----------------------------------------------------------------------------
package lif_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic RESET_SUBTRACT = 1'b0;
    localparam logic RESET_ZERO     = 1'b1;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        seg = 7'b0000000;
        if (digit <= 4'd9) begin
            seg = SEG_LUT[digit];
        end
        return seg;
    endfunction

endpackage

// File: rtl/lif_neuron_array_update.sv
// -----------------------------------------------------------------------------
// lif_update
// Purely combinational single-neuron LIF update.
//   u_i     : stored membrane potential U
//   i_i     : input current I
//   r_i     : refractory counter
//   thr_i   : firing threshold
//   mode_i  : RESET_SUBTRACT / RESET_ZERO
//   u_o     : next membrane potential U'
//   r_o     : next refractory counter
//   spike_o : neuron fires in this timestep
// -----------------------------------------------------------------------------
module lif_update
    import lif_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int BETA_SHIFT    = 2,
    parameter int REFRACT_STEPS = 2,
    parameter int RW            = 2
) (
    input  logic [WIDTH-1:0] u_i,
    input  logic [WIDTH-1:0] i_i,
    input  logic [RW-1:0]    r_i,
    input  logic [WIDTH-1:0] thr_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] u_o,
    output logic [RW-1:0]    r_o,
    output logic             spike_o
);

    logic [WIDTH-1:0] decayed;
    logic [WIDTH:0]   sum_wide;
    logic [WIDTH-1:0] sum_sat;

    // beta*U with beta = 1 - 2^-BETA_SHIFT, floor rounding
    assign decayed  = u_i - (u_i >> BETA_SHIFT);
    assign sum_wide = {1'b0, decayed} + {1'b0, i_i};
    // Clamp on carry-out so a large current never wraps the membrane to a small value
    assign sum_sat  = sum_wide[WIDTH] ? {WIDTH{1'b1}} : sum_wide[WIDTH-1:0];

    always_comb begin
        u_o     = sum_sat;
        r_o     = '0;
        spike_o = 1'b0;
        if (r_i != '0) begin
            // Refractory: leak only, input current is discarded
            u_o = decayed;
            r_o = r_i - 1'b1;
        end else if (sum_sat > thr_i) begin
            spike_o = 1'b1;
            r_o     = RW'(REFRACT_STEPS);
            u_o     = (mode_i == RESET_ZERO) ? '0 : (sum_sat - thr_i);
        end
    end

endmodule

// File: rtl/lif_neuron_array.sv
// -----------------------------------------------------------------------------
// lif_neuron_array
// Time-multiplexed array of NUM_NEURONS leaky integrate-and-fire neurons. One
// shared lif_update datapath visits neuron 0..N-1, one per cycle, per step.
//   clk, rst    : clock (rising edge), synchronous active-high reset
//   step_valid  : request one timestep
//   step_ready  : step can be accepted (IDLE)
//   current     : per-neuron input current, neuron i at [i*WIDTH +: WIDTH]
//   threshold   : firing threshold
//   reset_mode  : 0 = subtract threshold on fire, 1 = reset to zero
//   spikes      : spike vector of the last completed step
//   step_done   : one-cycle pulse when spikes is updated
//   mem_sel     : neuron selected for readback
//   mem_out     : membrane potential of mem_sel (0 when out of range)
//   segments    : only with LIF_SEG_DISPLAY_EN defined; 7-segment digit a..g
//                 showing neuron-0 spike count modulo 10
//
// Handshake: a step is accepted on a rising edge where step_valid && step_ready;
// current/threshold/reset_mode are captured on that edge. step_ready stays low
// until the step finishes, and step_valid is ignored while it is low.
// -----------------------------------------------------------------------------
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int NUM_NEURONS   = 4,
    parameter int WIDTH         = 8,
    parameter int BETA_SHIFT    = 2,
    parameter int REFRACT_STEPS = 2,
    localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         step_valid,
    output logic                         step_ready,
    input  logic [NUM_NEURONS*WIDTH-1:0] current,
    input  logic [WIDTH-1:0]             threshold,
    input  logic                         reset_mode,
    output logic [NUM_NEURONS-1:0]       spikes,
    output logic                         step_done,
    input  logic [IW-1:0]                mem_sel,
    output logic [WIDTH-1:0]             mem_out
`ifdef LIF_SEG_DISPLAY_EN
    ,
    output logic [6:0]                   segments
`endif
);

    localparam int RW = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURONS - 1);
    localparam logic [IW:0]   NUM_VAL  = (IW + 1)'(NUM_NEURONS);

    state_e state_q, state_d;

    logic [IW-1:0]          idx_q;
    logic [WIDTH-1:0]       cur_q  [NUM_NEURONS];
    logic [WIDTH-1:0]       thr_q;
    logic                   mode_q;
    logic [WIDTH-1:0]       mem_q  [NUM_NEURONS];
    logic [RW-1:0]          ref_q  [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] acc_q, acc_d;
    logic [NUM_NEURONS-1:0] spikes_q;

    logic [WIDTH-1:0]       u_next;
    logic [RW-1:0]          r_next;
    logic                   spike_w;
    logic                   last_idx;

    assign last_idx = (idx_q == LAST_IDX);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (step_valid) state_d = RUN;
            RUN:     if (last_idx)   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        step_ready = (state_q == IDLE);
        step_done  = (state_q == DONE);
    end

    // ---------------- shared update datapath ----------------
    lif_update #(
        .WIDTH        (WIDTH),
        .BETA_SHIFT   (BETA_SHIFT),
        .REFRACT_STEPS(REFRACT_STEPS),
        .RW           (RW)
    ) u_update (
        .u_i    (mem_q[idx_q]),
        .i_i    (cur_q[idx_q]),
        .r_i    (ref_q[idx_q]),
        .thr_i  (thr_q),
        .mode_i (mode_q),
        .u_o    (u_next),
        .r_o    (r_next),
        .spike_o(spike_w)
    );

    // Spike vector including the neuron being processed this cycle, so the
    // last neuron's result lands in spikes on the same edge that enters DONE.
    always_comb begin
        acc_d        = acc_q;
        acc_d[idx_q] = spike_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            thr_q    <= '0;
            mode_q   <= RESET_SUBTRACT;
            acc_q    <= '0;
            spikes_q <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                cur_q[n] <= '0;
                mem_q[n] <= '0;
                ref_q[n] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (step_valid) begin
                        idx_q  <= '0;
                        acc_q  <= '0;
                        thr_q  <= threshold;
                        mode_q <= reset_mode;
                        for (int n = 0; n < NUM_NEURONS; n++) begin
                            cur_q[n] <= current[n*WIDTH +: WIDTH];
                        end
                    end
                end
                RUN: begin
                    mem_q[idx_q] <= u_next;
                    ref_q[idx_q] <= r_next;
                    acc_q        <= acc_d;
                    idx_q        <= idx_q + 1'b1;
                    if (last_idx) begin
                        spikes_q <= acc_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign spikes = spikes_q;

    always_comb begin
        mem_out = '0;
        if ({1'b0, mem_sel} < NUM_VAL) begin
            mem_out = mem_q[mem_sel];
        end
    end

`ifdef LIF_SEG_DISPLAY_EN
    logic [3:0] seg_cnt_q;

    // spikes already holds the finished vector during DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_cnt_q <= 4'd0;
        end else if ((state_q == DONE) && spikes_q[0]) begin
            seg_cnt_q <= (seg_cnt_q == 4'd9) ? 4'd0 : seg_cnt_q + 4'd1;
        end
    end

    assign segments = seg_decode(seg_cnt_q);
`endif

endmodule

// File: tb/tb_lif_neuron_array.sv
module tb_lif_neuron_array;

    localparam int N = 4;
    localparam int W = 8;
    localparam int IW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             step_valid = 1'b0;
    logic             step_ready;
    logic [N*W-1:0]   current    = '0;
    logic [W-1:0]     threshold  = '0;
    logic             reset_mode = 1'b0;
    logic [N-1:0]     spikes;
    logic             step_done;
    logic [IW-1:0]    mem_sel    = '0;
    logic [W-1:0]     mem_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];

`ifdef LIF_SEG_DISPLAY_EN
    logic [6:0]   segments;
    logic [6:0]   seg_segments;
    logic         seg_ready;
    logic [N-1:0] seg_spikes;
    logic         seg_done;
    logic [W-1:0] seg_mem;
`endif

    lif_neuron_array #(
        .NUM_NEURONS(N), .WIDTH(W), .BETA_SHIFT(2), .REFRACT_STEPS(2)
    ) dut (
        .clk(clk), .rst(rst), .step_valid(step_valid), .step_ready(step_ready),
        .current(current), .threshold(threshold), .reset_mode(reset_mode),
        .spikes(spikes), .step_done(step_done), .mem_sel(mem_sel), .mem_out(mem_out)
`ifdef LIF_SEG_DISPLAY_EN
        , .segments(segments)
`endif
    );

`ifdef LIF_SEG_DISPLAY_EN
    lif_neuron_array #(
        .NUM_NEURONS(N), .WIDTH(W), .BETA_SHIFT(2), .REFRACT_STEPS(0)
    ) dut_seg (
        .clk(clk), .rst(rst), .step_valid(step_valid), .step_ready(seg_ready),
        .current(current), .threshold(threshold), .reset_mode(reset_mode),
        .spikes(seg_spikes), .step_done(seg_done), .mem_sel(mem_sel), .mem_out(seg_mem),
        .segments(seg_segments)
    );
`endif

    // ---------------- scoreboard helper ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        step_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Run one timestep; returns the spike vector sampled in the step_done cycle.
    task automatic run_step(input string tag, output logic [N-1:0] sp);
        int wait_cyc;
        int edges;
        wait_cyc = 0;
        while (!step_ready && wait_cyc < 20) begin
            @(posedge clk);
            #1 wait_cyc++;
        end
        check({tag, "_ready"}, step_ready, 1);
        step_valid = 1'b1;
        @(posedge clk);
        #1 step_valid = 1'b0;
        edges = 0;
        while (!step_done && edges < 20) begin
            @(posedge clk);
            #1 edges++;
        end
        // cycles counted from the accept cycle through the step_done cycle
        check({tag, "_latency"}, edges + 1, N + 1);
        sp = spikes;
    endtask

    task automatic read_mem(input int n, output logic [W-1:0] v);
        mem_sel = IW'(n);
        #1 v = mem_out;
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        logic [N-1:0] sp;
        logic [W-1:0] v;

        // Reset state
        do_reset();
        check("rst_ready", step_ready, 1);
        check("rst_done", step_done, 0);
        check("rst_spikes", spikes, 0);
        for (int n = 0; n < N; n++) begin
            read_mem(n, v);
            check("rst_mem", v, 0);
        end

        // Integrate to threshold, subtract reset, refractory
        threshold  = 8'd100;
        reset_mode = 1'b0;
        current    = {8'd0, 8'd0, 8'd0, 8'd30};
        exp_q = {};
        exp_q.push_back(8'd30);  exp_q.push_back(8'd53);  exp_q.push_back(8'd70);
        exp_q.push_back(8'd83);  exp_q.push_back(8'd93);  exp_q.push_back(8'd100);
        exp_q.push_back(8'd5);   exp_q.push_back(8'd4);   exp_q.push_back(8'd3);
        exp_q.push_back(8'd33);
        for (int s = 1; s <= 10; s++) begin
            logic [W-1:0] e;
            run_step("sub", sp);
            e = exp_q.pop_front();
            check("sub_spikes", sp, (s == 7) ? 4'b0001 : 4'b0000);
            read_mem(0, v);
            check("sub_u0", v, e);
        end
        read_mem(1, v);
        check("sub_u1_idle", v, 0);

        // Same stimulus, reset-to-zero
        do_reset();
        reset_mode = 1'b1;
        for (int s = 1; s <= 7; s++) begin
            run_step("zero", sp);
        end
        check("zero_spikes", sp, 4'b0001);
        read_mem(0, v);
        check("zero_u0", v, 0);

        // Saturation and all-ones threshold
        do_reset();
        reset_mode = 1'b0;
        threshold  = 8'd255;
        current    = {8'd255, 8'd255, 8'd255, 8'd255};
        run_step("sat1", sp);
        check("sat1_spikes", sp, 0);
        read_mem(0, v);
        check("sat1_u0", v, 255);
        run_step("sat2", sp);
        check("sat2_spikes_thr_max", sp, 0);
        read_mem(3, v);
        check("sat2_u3", v, 255);
        threshold = 8'd254;
        run_step("sat3", sp);
        check("sat3_spikes", sp, 4'b1111);
        read_mem(0, v);
        check("sat3_u0", v, 1);
        read_mem(3, v);
        check("sat3_u3", v, 1);

        // Zero threshold: zero sum does not fire, nonzero sum does
        do_reset();
        threshold = 8'd0;
        current   = '0;
        run_step("thr0a", sp);
        check("thr0a_spikes", sp, 0);
        current = {8'd0, 8'd0, 8'd0, 8'd1};
        run_step("thr0b", sp);
        check("thr0b_spikes", sp, 4'b0001);
        read_mem(0, v);
        check("thr0b_u0", v, 1);

        // Handshake with step_valid held high
        do_reset();
        threshold = 8'd100;
        current   = {8'd0, 8'd0, 8'd0, 8'd30};
        @(posedge clk);
        #1 step_valid = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk);
            #1;
            check("hs_ready", step_ready, (k % 6 == 0) ? 1 : 0);
            check("hs_done", step_done, (k % 6 == 5) ? 1 : 0);
        end
        step_valid = 1'b0;
        @(posedge clk);
        #1;
        read_mem(0, v);
        check("hs_u0_three_steps", v, 70);

        // Reset during the second RUN cycle
        step_valid = 1'b1;
        @(posedge clk);
        #1 step_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rr_ready", step_ready, 1);
        check("rr_done", step_done, 0);
        check("rr_spikes", spikes, 0);
        for (int n = 0; n < N; n++) begin
            read_mem(n, v);
            check("rr_mem", v, 0);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check("rr_no_done", step_done, 0);
        end

`ifdef LIF_SEG_DISPLAY_EN
        // Spike counter digit: neuron 0 fires every step without refractory
        do_reset();
        check("seg_rst", seg_segments, 7'b0111111);
        threshold = 8'd0;
        current   = {8'd0, 8'd0, 8'd0, 8'd1};
        for (int s = 1; s <= 12; s++) begin
            run_step("seg", sp);
        end
        @(posedge clk);
        #1;
        check("seg_digit2", seg_segments, 7'b1011011);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
